// File: rtl/shift_pkg.sv
// Shared constants for the serial shift-register path: bit-order codes,
// FSM state encoding and the default word width.
package shift_pkg;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam int DEFAULT_WIDTH = 4;

endpackage : shift_pkg

// File: rtl/serial_deserializer_if.sv
// Bus bundle for the serial deserializer: serial input side, parallel
// output side and status.
//
// Handshake: a serial bit transfers on a rising edge where s_valid=1 (there is
// no backpressure on the serial side). A parallel word transfers on a rising
// edge where p_valid=1 and p_ready=1; p_data is held stable while p_valid=1 and
// p_ready=0, and p_valid never drops without a transfer (except on reset).
interface serial_deserializer_if
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
);
   logic             s_valid;
   logic             s_data;
   logic             dir;
   logic             clear;
   logic             p_ready;
   logic [WIDTH-1:0] p_data;
   logic             p_valid;
   logic             busy;
   logic [CNT_W-1:0] bit_cnt;
   logic             overflow;
   logic [0:0]       fsm_state;

   // Producer/consumer side (drives the serial stream, consumes words)
   modport master (
      output s_valid, s_data, dir, clear, p_ready,
      input  p_data, p_valid, busy, bit_cnt, overflow, fsm_state
   );

   // Deserializer side
   modport slave (
      input  s_valid, s_data, dir, clear, p_ready,
      output p_data, p_valid, busy, bit_cnt, overflow, fsm_state
   );

endinterface : serial_deserializer_if

// File: rtl/serial_deserializer_out_reg.sv
// One-word holding register with valid/ready output and sticky overflow.
// A load arriving while the held word is not being consumed is dropped.
module deser_out_reg
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   input  logic             p_ready,
   output logic [WIDTH-1:0] p_data,
   output logic             p_valid,
   output logic             overflow
);

   logic [WIDTH-1:0] p_data_q,   p_data_d;
   logic             p_valid_q,  p_valid_d;
   logic             overflow_q, overflow_d;
   logic             slot_free;

   // The slot can take a new word if empty or emptied on this same edge
   assign slot_free = !p_valid_q || p_ready;

   // Next-state for load / consume / drop
   always_comb begin
      p_data_d   = p_data_q;
      p_valid_d  = p_valid_q;
      overflow_d = overflow_q;
      if (load_valid && slot_free) begin
         p_data_d  = load_data;
         p_valid_d = 1'b1;
      end else if (p_valid_q && p_ready) begin
         p_valid_d = 1'b0;
      end
      if (load_valid && !slot_free) begin
         overflow_d = 1'b1;
      end
   end

   // State registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         p_data_q   <= '0;
         p_valid_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         p_data_q   <= p_data_d;
         p_valid_q  <= p_valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign p_data   = p_data_q;
   assign p_valid  = p_valid_q;
   assign overflow = overflow_q;

endmodule : deser_out_reg

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: shifts qualified serial bits into a WIDTH-bit
// word in the order latched at the first bit, and hands completed words to
// a one-word output holding register.
module serial_deserializer
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_deserializer_if.slave bus
);

   logic [WIDTH-1:0] sr_q,      sr_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [0:0]       state_q,   state_d;
   logic             dir_q,     dir_d;

   logic             eff_dir;
   logic             last_bit;
   logic             complete;
   logic [WIDTH-1:0] shifted;

   // The first bit of a word uses the live dir; later bits use the latched one
   assign eff_dir  = (state_q == ST_IDLE) ? bus.dir : dir_q;
   assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));
   assign complete = bus.s_valid && !bus.clear && last_bit;

   // Shift register with the incoming bit inserted per bit order
   always_comb begin
      shifted = sr_q;
      if (eff_dir == DIR_MSB_FIRST) begin
         shifted = {sr_q[WIDTH-2:0], bus.s_data};
      end else begin
         shifted = {bus.s_data, sr_q[WIDTH-1:1]};
      end
   end

   // Word-assembly FSM: clear aborts, accepted bits advance, last bit wraps
   always_comb begin
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      state_d   = state_q;
      dir_d     = dir_q;
      if (bus.clear) begin
         sr_d      = '0;
         bit_cnt_d = '0;
         state_d   = ST_IDLE;
      end else if (bus.s_valid) begin
         if (state_q == ST_IDLE) begin
            dir_d = bus.dir;
         end
         if (last_bit) begin
            sr_d      = '0;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
         end else begin
            sr_d      = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            state_d   = ST_SHIFT;
         end
      end
   end

   // State registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         sr_q      <= '0;
         bit_cnt_q <= '0;
         state_q   <= ST_IDLE;
         dir_q     <= DIR_LSB_FIRST;
      end else begin
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         state_q   <= state_d;
         dir_q     <= dir_d;
      end
   end

   deser_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load_valid (complete),
      .load_data  (shifted),
      .p_ready    (bus.p_ready),
      .p_data     (bus.p_data),
      .p_valid    (bus.p_valid),
      .overflow   (bus.overflow)
   );

   assign bus.busy      = (bit_cnt_q != '0);
   assign bus.bit_cnt   = bit_cnt_q;
   assign bus.fsm_state = state_q;

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (WIDTH=4): stimulus pushes expected
// words into a queue, a monitor pops and compares on every output handshake.
module tb_serial_deserializer;
   import shift_pkg::*;

   localparam int W = 4;

   logic clk;
   logic rst;

   serial_deserializer_if #(.WIDTH(W)) bus ();

   serial_deserializer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   int words_seen = 0;
   logic [W-1:0] exp_q[$];

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Monitor: every word handshake must match the head of the expected queue
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && bus.p_valid === 1'b1 && bus.p_ready === 1'b1) begin
            words_seen++;
            if (exp_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_word: got %0h, expected none", bus.p_data);
            end else begin
               check("word", {28'd0, bus.p_data}, {28'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic d);
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      bus.dir     = d;
      tick();
      bus.s_valid = 1'b0;
      bus.s_data  = 1'b0;
   endtask

   // Sends seq[3] first, seq[0] last
   task automatic send_seq(input logic [3:0] seq, input logic d);
      for (int i = 3; i >= 0; i--) send_bit(seq[i], d);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = 1'b0;
      bus.dir     = 1'b0;
      bus.clear   = 1'b0;
      bus.p_ready = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      check("rst_p_data",   {28'd0, bus.p_data}, 32'd0);
      check("rst_p_valid",  {31'd0, bus.p_valid}, 32'd0);
      check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
      check("rst_busy",     {31'd0, bus.busy}, 32'd0);
      check("rst_bit_cnt",  {30'd0, bus.bit_cnt}, 32'd0);
      rst = 1'b1;

      // LSB-first 1,0,1,1 -> 1101
      bus.p_ready = 1'b1;
      exp_q.push_back(4'b1101);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      check("mid_bit_cnt", {30'd0, bus.bit_cnt}, 32'd2);
      check("mid_busy",    {31'd0, bus.busy}, 32'd1);
      check("mid_state",   {31'd0, bus.fsm_state}, {31'd0, ST_SHIFT});
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      check("t1_p_valid", {31'd0, bus.p_valid}, 32'd1);
      check("t1_p_data",  {28'd0, bus.p_data}, 32'hD);
      check("t1_bit_cnt", {30'd0, bus.bit_cnt}, 32'd0);
      tick();
      check("t1_consumed", {31'd0, bus.p_valid}, 32'd0);

      // MSB-first with gaps, dir toggled after the first bit -> 1011
      exp_q.push_back(4'b1011);
      send_bit(1'b1, 1'b1);
      bus.dir = 1'b0;
      tick();
      tick();
      check("gap_hold_cnt", {30'd0, bus.bit_cnt}, 32'd1);
      send_bit(1'b0, 1'b0);
      tick();
      bus.dir = 1'b1;
      tick();
      send_bit(1'b1, 1'b0);
      tick();
      tick();
      send_bit(1'b1, 1'b0);
      check("t2_p_data", {28'd0, bus.p_data}, 32'hB);
      tick();

      // Overflow: p_ready low, 0101 held, 1110 dropped
      bus.p_ready = 1'b0;
      exp_q.push_back(4'b0101);
      send_seq(4'b1010, 1'b0);
      send_seq(4'b0111, 1'b0);
      check("ovf_p_data",  {28'd0, bus.p_data}, 32'h5);
      check("ovf_p_valid", {31'd0, bus.p_valid}, 32'd1);
      check("ovf_flag",    {31'd0, bus.overflow}, 32'd1);
      bus.p_ready = 1'b1;
      tick();
      check("ovf_drain",  {31'd0, bus.p_valid}, 32'd0);
      check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

      // Back-to-back: consume and load on the same edge, then stream
      do_reset();
      words_seen = 0;
      bus.p_ready = 1'b0;
      exp_q.push_back(4'b0011);
      send_seq(4'b1100, 1'b0);
      exp_q.push_back(4'b1001);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      bus.p_ready = 1'b1;
      send_bit(1'b1, 1'b0);
      check("b2b_p_valid", {31'd0, bus.p_valid}, 32'd1);
      check("b2b_p_data",  {28'd0, bus.p_data}, 32'h9);
      exp_q.push_back(4'b0110);
      send_seq(4'b0110, 1'b0);
      tick();
      check("b2b_overflow", {31'd0, bus.overflow}, 32'd0);
      check("b2b_count",    words_seen, 32'd3);

      // Clear aborts a partial word
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      bus.clear   = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 1'b1;
      tick();
      bus.clear   = 1'b0;
      bus.s_valid = 1'b0;
      check("clr_bit_cnt", {30'd0, bus.bit_cnt}, 32'd0);
      check("clr_busy",    {31'd0, bus.busy}, 32'd0);
      exp_q.push_back(4'b1100);
      send_seq(4'b0011, 1'b0);
      check("clr_p_data", {28'd0, bus.p_data}, 32'hC);
      tick();

      // Reset mid-word with a held word
      bus.p_ready = 1'b0;
      send_seq(4'b1110, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      rst = 1'b0;
      tick();
      check("mrst_p_valid", {31'd0, bus.p_valid}, 32'd0);
      check("mrst_p_data",  {28'd0, bus.p_data}, 32'd0);
      check("mrst_bit_cnt", {30'd0, bus.bit_cnt}, 32'd0);
      check("mrst_busy",    {31'd0, bus.busy}, 32'd0);
      rst = 1'b1;
      bus.p_ready = 1'b1;
      exp_q.push_back(4'b1010);
      send_seq(4'b0101, 1'b0);
      check("post_rst_p_data", {28'd0, bus.p_data}, 32'hA);
      tick();
      tick();
      check("queue_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_serial_deserializer
